// File: rtl/mtimer_pkg.sv
// Shared constants and helpers for the machine timer and its consumers.
package mtimer_pkg;

    // Word offsets of the timer registers on the data-memory bus
    localparam logic [2:0] MTIMER_MTIME_LO = 3'd0;
    localparam logic [2:0] MTIMER_MTIME_HI = 3'd1;
    localparam logic [2:0] MTIMER_CMP_LO   = 3'd2;
    localparam logic [2:0] MTIMER_CMP_HI   = 3'd3;
    localparam logic [2:0] MTIMER_CTRL     = 3'd4;

    // Position of the timer interrupt pending bit inside mip
    localparam int MTIP_BIT = 7;

    // Replace the bytes of oldWord selected by strb with those of newWord
    function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                               input logic [31:0] newWord,
                                               input logic [3:0]  strb);
        logic [31:0] result;
        result = oldWord;
        for (int b = 0; b < 4; b++) begin
            if (strb[b]) begin
                result[b*8 +: 8] = newWord[b*8 +: 8];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Divides clk down to a one-cycle tick every PRESCALE enabled cycles.
module mtimer_prescaler
    import mtimer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_en,
    output logic o_tick
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

    logic [CW-1:0] r_count;
    logic          w_atLast;

    assign w_atLast = (r_count == LAST);
    assign o_tick   = i_en && w_atLast;

    // Count enabled cycles, wrapping after the last one; disabled cycles freeze the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_en) begin
            if (w_atLast) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mtimer.sv
// Memory-mapped 64-bit machine timer with compare register and interrupt level.
module mtimer
    import mtimer_pkg::*;
#(
    parameter int          PRESCALE  = 1,
    parameter logic [63:0] CMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sel,
    input  logic        we,
    input  logic [2:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wstrb,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        mtip
);

    logic [63:0] r_mtime;
    logic [63:0] r_mtimeCmp;
    logic        r_en;
    logic [31:0] r_hiShadow;
    logic [31:0] r_rdata;
    logic        r_rvalid;
    logic        r_mtip;

    logic        w_tick;
    logic        w_write;
    logic        w_read;
    logic [31:0] w_rdataNext;

    assign w_write = sel && we;
    assign w_read  = sel && !we;

    mtimer_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_en   (r_en),
        .o_tick (w_tick)
    );

    // mtime: a bus write to either half wins over the tick and suppresses the increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtime <= 64'd0;
        end else if (w_write && (addr == MTIMER_MTIME_LO)) begin
            r_mtime[31:0] <= mergeBytes(r_mtime[31:0], wdata, wstrb);
        end else if (w_write && (addr == MTIMER_MTIME_HI)) begin
            r_mtime[63:32] <= mergeBytes(r_mtime[63:32], wdata, wstrb);
        end else if (w_tick) begin
            r_mtime <= r_mtime + 64'd1;
        end
    end

    // mtimecmp halves and the enable bit are plain byte-writable registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtimeCmp <= CMP_RESET;
            r_en       <= 1'b1;
        end else if (w_write) begin
            if (addr == MTIMER_CMP_LO) begin
                r_mtimeCmp[31:0] <= mergeBytes(r_mtimeCmp[31:0], wdata, wstrb);
            end
            if (addr == MTIMER_CMP_HI) begin
                r_mtimeCmp[63:32] <= mergeBytes(r_mtimeCmp[63:32], wdata, wstrb);
            end
            if ((addr == MTIMER_CTRL) && wstrb[0]) begin
                r_en <= wdata[0];
            end
        end
    end

    // Read multiplexer; the high mtime word comes from the shadow captured by the low read
    always_comb begin
        w_rdataNext = 32'd0;
        case (addr)
            MTIMER_MTIME_LO: w_rdataNext = r_mtime[31:0];
            MTIMER_MTIME_HI: w_rdataNext = r_hiShadow;
            MTIMER_CMP_LO:   w_rdataNext = r_mtimeCmp[31:0];
            MTIMER_CMP_HI:   w_rdataNext = r_mtimeCmp[63:32];
            MTIMER_CTRL:     w_rdataNext = {31'd0, r_en};
            default:         w_rdataNext = 32'd0;
        endcase
    end

    // Registered read response; a low-word read also snapshots the high word for tear-free pairs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata    <= 32'd0;
            r_rvalid   <= 1'b0;
            r_hiShadow <= 32'd0;
        end else begin
            r_rvalid <= w_read;
            if (w_read) begin
                r_rdata <= w_rdataNext;
                if (addr == MTIMER_MTIME_LO) begin
                    r_hiShadow <= r_mtime[63:32];
                end
            end
        end
    end

    // Interrupt level from the pre-update register values, so it trails the crossing by a cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mtip <= 1'b0;
        end else begin
            r_mtip <= (r_mtime >= r_mtimeCmp);
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign mtip   = r_mtip;

endmodule

// File: doc/mtimer.md
Name: mtimer

Overview:
- Memory-mapped machine timer. It holds a 64-bit mtime counter and a 64-bit mtimecmp compare register.
- It drives the mtip level into the CSR block, where that level appears as mip.MTIP (bit 7) and gates the timer interrupt.
- It sits on the data-memory bus beside datamem and is selected by the address decoder. It is the source end of the mtip signal that the CSR block consumes.

Parameters:
- PRESCALE, 1, clk cycles per mtime increment (>=1).
- CMP_RESET, 64'hFFFF_FFFF_FFFF_FFFF, reset value of mtimecmp; keeps mtip low out of reset.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- sel  input  1  bus access targets this block this cycle
- we  input  1  1=write, 0=read (qualified by sel)
- addr  input  3  word offset: 0=mtime_lo, 1=mtime_hi, 2=mtimecmp_lo, 3=mtimecmp_hi, 4=ctrl; 5-7 reserved
- wdata  input  32  write data
- wstrb  input  4  byte enables for writes
- rdata  output  32  registered read data
- rvalid  output  1  high one cycle after an accepted read
- mtip  output  1  machine timer interrupt pending, registered level

Behaviour:
- Reset is asynchronous on rst_n low. Reset values:
  - mtime = 0
  - mtimecmp = CMP_RESET
  - ctrl.en (bit 0) = 1
  - prescale counter = 0
  - hi_shadow = 0
  - rdata = 0
  - rvalid = 0
  - mtip = 0
- Prescaler:
  - Counter runs 0..PRESCALE-1 while ctrl.en=1.
  - tick is asserted when the counter equals PRESCALE-1. The counter then wraps to 0.
  - With PRESCALE=1, tick is asserted every cycle.
  - ctrl.en=0 freezes both the counter and mtime.
- Increment: on tick, mtime <= mtime + 1 as a full 64-bit add. Carry propagates lo→hi. 64'hFFFF_FFFF_FFFF_FFFF wraps to 0.
- Writes (sel & we):
  - Apply wstrb per byte to the addressed 32-bit half.
  - A write to either mtime half takes priority over the tick in the same cycle. That cycle the written half takes the new bytes, the other half holds, and no increment or carry occurs. The prescale counter still advances.
  - ctrl writes: bit 0 is en; other bits are ignored and read as 0.
  - Reserved addresses: writes are ignored.
- Reads (sel & ~we):
  - rdata and rvalid update at the next clk edge (1-cycle latency).
  - Reserved addresses read as 0.
  - A read of addr 0 returns mtime[31:0] and also latches mtime[63:32] into hi_shadow in the same edge.
  - A read of addr 1 returns hi_shadow, not the live value. This gives a tear-free lo-then-hi read pair.
  - mtimecmp halves read live.
  - rvalid=0 and rdata holds its last value when there is no read.
- Interrupt:
  - mtip <= (mtime >= mtimecmp), unsigned 64-bit compare.
  - The compare is evaluated on register values before this cycle's update, so mtip lags the crossing by one cycle.
  - mtip is a level. It is cleared only by moving mtimecmp above mtime, or by writing mtime below mtimecmp.
  - Between two half-writes, a partial mtimecmp may briefly assert mtip. This is software's concern: write hi = all-ones first.
- Simultaneous events:
  - The block accepts one bus access per cycle. A read and a write in the same cycle are impossible.
  - A write to mtimecmp coincident with a tick: both take effect, and the compare next cycle uses both new values.
- Reset mid-operation forces every register to its reset value immediately, independent of clk. An in-flight read produces no rvalid.

Decomposition:
- A shared package holds:
  - the address constants MTIMER_MTIME_LO=0, MTIMER_MTIME_HI=1, MTIMER_CMP_LO=2, MTIMER_CMP_HI=3, MTIMER_CTRL=4;
  - the mip bit index MTIP_BIT=7, also used by the CSR block.
- One sub-module is natural: mtimer_prescaler, containing the counter, en gating and tick output.
- The remaining logic (registers, compare, bus port) stays flat in mtimer.

Test Plan:
- Reset release, PRESCALE=1 → mtip=0. Read addr 0 after 10 cycles returns 10 ±1; rvalid is high exactly one cycle after sel.
- Write mtimecmp_hi=0, then mtimecmp_lo=20 while mtime≈5 → mtip stays 0 until mtime reaches 20, then is 1 on the following cycle. Write mtimecmp_hi=32'hFFFF_FFFF → mtip=0 one cycle later.
- Write mtime_lo=32'hFFFF_FFFE, mtime_hi=0, let it tick 3 times → mtime=64'h1_0000_0001 (carry into hi).
- Write mtime_lo=32'hFFFF_FFFF, then read addr 0 on the cycle before the carry and read addr 1 afterwards → hi read returns 0 (shadow), not 1.
- PRESCALE=4, ctrl.en=1 → mtime increments once every 4 cycles. Write ctrl=0 → mtime is frozen for 20 cycles. Write ctrl=1 → counting resumes.
- Write wstrb=4'b0010, wdata=32'h0000_AB00 to mtimecmp_lo (was all-ones) → reads back 32'hFFFF_ABFF. Assert rst_n low mid-count → mtime=0 and mtip=0 asynchronously.
